// File: rtl/bin_bcd_pkg.sv
// Shared types and sizing helper for the sequential binary-to-BCD converter.
package bin_bcd_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

   // BCD result width for a w-bit binary operand
   function automatic int unsigned bcd_width(input int unsigned w);
      return w + (w - 4) / 3 + 1;
   endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift in the next binary bit.
module bcd_dabble_step #(
   parameter int unsigned BCD_W = 42
) (
   input  logic [BCD_W-1:0] acc,
   input  logic             bit_in,
   output logic [BCD_W-1:0] acc_next
);

   localparam int unsigned NDIG = BCD_W / 4;

   logic [BCD_W-1:0] adj;

   // A partial top digit never reaches 5, so only full digits are corrected
   always_comb begin
      adj = acc;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (acc[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
         end
      end
   end

   // The bit shifted out of the top is always 0 for legal operand widths
   assign acc_next = BCD_W'({adj, bit_in});

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble iteration per clock, valid/ready on both sides.
module bin2bcd_seq
   import bin_bcd_pkg::*;
#(
   parameter  int unsigned W     = 32,
   localparam int unsigned BCD_W = bcd_width(W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BCD_W-1:0] Bcd,
   output logic             busy
);

   localparam int unsigned CW = $clog2(W + 1);

   bcd_state_t       state;
   bcd_state_t       state_nx;
   logic [CW-1:0]    cnt;
   logic [W-1:0]     sreg;
   logic [BCD_W-1:0] acc;
   logic [BCD_W-1:0] acc_step;

   bcd_dabble_step #(.BCD_W(BCD_W)) u_step (
      .acc      (acc),
      .bit_in   (sreg[W-1]),
      .acc_next (acc_step)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)        state_nx = SHIFT;
         SHIFT:   if (cnt == CW'(1))   state_nx = DONE;
         DONE:    if (out_ready)       state_nx = IDLE;
         default:                      state_nx = IDLE;
      endcase
   end

   // Handshake flags are pure decodes of the registered state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE:    in_ready = 1'b1;
         SHIFT:   busy     = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   // Operand shift register, accumulator and iteration counter
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= '0;
         acc  <= '0;
         cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sreg <= Bin;
                  acc  <= '0;
                  cnt  <= CW'(W);
               end
            end
            SHIFT: begin
               acc  <= acc_step;
               sreg <= sreg << 1;
               cnt  <= cnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign Bcd = acc;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq at W=32 and W=8: vector table, corner sequences, random jobs.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv;
   logic        orr;
   logic        use8;
   logic [31:0] b;

   logic        ir32, ov32, busy32;
   logic [41:0] bcd32;
   logic        ir8, ov8, busy8;
   logic [9:0]  bcd8;

   logic        irm, ovm, busym;
   logic [63:0] bcdm;
   int          wlat;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.W(32)) dut32 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv & ~use8),
      .in_ready  (ir32),
      .Bin       (b),
      .out_valid (ov32),
      .out_ready (orr),
      .Bcd       (bcd32),
      .busy      (busy32)
   );

   bin2bcd_seq #(.W(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv & use8),
      .in_ready  (ir8),
      .Bin       (b[7:0]),
      .out_valid (ov8),
      .out_ready (orr),
      .Bcd       (bcd8),
      .busy      (busy8)
   );

   always_comb begin
      irm   = use8 ? ir8   : ir32;
      ovm   = use8 ? ov8   : ov32;
      busym = use8 ? busy8 : busy32;
      bcdm  = use8 ? 64'(bcd8) : 64'(bcd32);
      wlat  = use8 ? 8 : 32;
   end

   function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endfunction

   // Reference: decimal digits of the value, one nibble each
   function automatic logic [63:0] ref_bcd(input longint unsigned v);
      logic [63:0]     r;
      longint unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < 16; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // One job: offer bin, check latency and result, optional hold with in_valid pulses, then retire
   task automatic run_job(input logic [31:0] bin, input logic [63:0] exp, input int hold, input bit rnd);
      int n;
      int k;
      bit rdy;
      check("idle_before_job", 64'(irm), 64'd1);
      iv = 1'b1;
      b  = bin;
      @(negedge clk);
      iv = 1'b0;
      b  = $urandom;
      n  = 0;
      while (!ovm && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("latency", 64'(n), 64'(wlat));
      check("bcd", bcdm, exp);
      for (int i = 0; i < hold; i++) begin
         orr = 1'b0;
         iv  = 1'b1;
         b   = $urandom;
         @(negedge clk);
         check("hold_ov", 64'(ovm), 64'd1);
         check("hold_in_ready", 64'(irm), 64'd0);
         check("hold_bcd", bcdm, exp);
      end
      iv = 1'b0;
      if (rnd) begin
         k = 0;
         do begin
            rdy = 1'($urandom % 2);
            orr = rdy;
            @(negedge clk);
            if (!rdy) check("stall_bcd", bcdm, exp);
            k++;
         end while (!rdy && k < 64);
         if (!rdy) begin
            orr = 1'b1;
            @(negedge clk);
         end
      end else begin
         orr = 1'b1;
         @(negedge clk);
      end
      check("retire_in_ready", 64'(irm), 64'd1);
      check("retire_ov", 64'(ovm), 64'd0);
   endtask

   typedef struct {
      bit          w8;
      logic [31:0] bin;
      logic [63:0] exp;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int seen;
      logic [31:0] rb;

      tbl[0] = '{1'b0, 32'd0,          64'h0};
      tbl[1] = '{1'b0, 32'hFFFF_FFFF,  64'h04294967295};
      tbl[2] = '{1'b0, 32'd255,        64'h255};
      tbl[3] = '{1'b0, 32'd1234,       64'h1234};
      tbl[4] = '{1'b0, 32'd9,          64'h9};
      tbl[5] = '{1'b0, 32'd10,         64'h10};
      tbl[6] = '{1'b0, 32'd99999999,   64'h99999999};
      tbl[7] = '{1'b0, 32'd1000000000, 64'h1000000000};
      tbl[8] = '{1'b1, 32'd255,        64'h255};
      tbl[9] = '{1'b1, 32'd100,        64'h100};

      rst  = 1'b1;
      iv   = 1'b0;
      orr  = 1'b0;
      use8 = 1'b0;
      b    = '0;

      // Reset for two clocks, then idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(ir32), 64'd1);
      check("rst_out_valid", 64'(ov32), 64'd0);
      check("rst_busy", 64'(busy32), 64'd0);
      check("rst_bcd", 64'(bcd32), 64'h0);
      check("rst_busy8", 64'(busy8), 64'd0);

      // Vector table; out_ready is held high through SHIFT with no effect
      foreach (tbl[i]) begin
         use8 = tbl[i].w8;
         orr  = 1'b1;
         run_job(tbl[i].bin, tbl[i].exp, 0, 1'b0);
      end
      use8 = 1'b0;

      // Stalled consumer for 5 clocks with in_valid offered meanwhile
      run_job(32'd255, 64'h255, 5, 1'b0);
      repeat (3) @(negedge clk);
      check("no_second_accept_busy", 64'(busy32), 64'd0);
      check("no_second_accept_ov", 64'(ov32), 64'd0);

      // Reset at SHIFT cycle 10 discards the job
      orr = 1'b0;
      iv  = 1'b1;
      b   = 32'd99;
      @(negedge clk);
      iv = 1'b0;
      repeat (9) @(negedge clk);
      check("mid_shift_busy", 64'(busy32), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (ov32) seen++;
      end
      check("rst_shift_no_ov", 64'(seen), 64'd0);
      run_job(32'd1234, 64'h1234, 0, 1'b0);

      // Reset while a result waits in DONE
      orr = 1'b0;
      iv  = 1'b1;
      b   = 32'd77;
      @(negedge clk);
      iv = 1'b0;
      repeat (32) @(negedge clk);
      check("done_before_rst", 64'(ov32), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_done_ov", 64'(ov32), 64'd0);
      check("rst_done_in_ready", 64'(ir32), 64'd1);
      run_job(32'd42, 64'h42, 0, 1'b0);

      // Random back-to-back jobs, W=32
      use8 = 1'b0;
      for (int j = 0; j < 700; j++) begin
         case ($urandom % 8)
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         orr = 1'($urandom % 2);
         run_job(rb, ref_bcd(64'(rb)), 0, 1'b1);
      end

      // Random back-to-back jobs, W=8
      use8 = 1'b1;
      for (int j = 0; j < 1500; j++) begin
         rb  = 32'($urandom_range(0, 255));
         orr = 1'($urandom % 2);
         run_job(rb, ref_bcd(64'(rb)), 0, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
